// File: rtl/mult_seq_ctrl_pkg.sv
// mult_seq_ctrl_pkg
//   Shared definitions for the sequential shift-and-add multiplier:
//   FSM state encoding and the default operand width.
package mult_seq_ctrl_pkg;

    localparam int W_DEFAULT = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage : mult_seq_ctrl_pkg

// File: rtl/mult_seq_ctrl_add_slice.sv
// add_slice
//   Combinational W-bit ripple-carry adder built from 1-bit full-adder cells.
//   Ports:
//     x, y  in  W   addends
//     cin   in  1   carry-in
//     sum   out W   sum bits
//     cout  out 1   carry-out of the top cell
module fa_cell (
    input  logic x,
    input  logic y,
    input  logic ci,
    output logic s,
    output logic co
);
    assign s  = x ^ y ^ ci;
    assign co = (x & y) | (ci & (x ^ y));
endmodule : fa_cell

module add_slice
    import mult_seq_ctrl_pkg::*;
#(
    parameter int W = W_DEFAULT
) (
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    input  logic         cin,
    output logic [W-1:0] sum,
    output logic         cout
);
    // c[i] is the carry into bit i; c[W] leaves the slice.
    logic [W:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < W; i++) begin : g_fa
        fa_cell u_fa (
            .x  (x[i]),
            .y  (y[i]),
            .ci (c[i]),
            .s  (sum[i]),
            .co (c[i+1])
        );
    end

    assign cout = c[W];

endmodule : add_slice

// File: rtl/mult_seq_ctrl.sv
// mult_seq_ctrl
//   Sequential unsigned shift-and-add multiplier. One shared W-bit adder
//   slice is used once per iteration; W iterations form a 2W-bit product.
//   Ports:
//     clk      in  1   rising-edge clock
//     rst_n    in  1   asynchronous active-low reset
//     start    in  1   begin a multiply (only honoured in IDLE)
//     a        in  W   multiplicand, captured on the accepting edge
//     b        in  W   multiplier, captured on the accepting edge
//     busy     out 1   high while iterating (RUN)
//     done     out 1   one-cycle pulse when product is written
//     product  out 2W  last completed result
module mult_seq_ctrl
    import mult_seq_ctrl_pkg::*;
#(
    parameter int W  = W_DEFAULT,
    parameter int CW = $clog2(W)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    output logic           busy,
    output logic           done,
    output logic [2*W-1:0] product
);
    localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);

    state_e           state_q, state_d;
    logic [W-1:0]     mcand_q, mcand_d;
    logic [2*W-1:0]   acc_q, acc_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [2*W-1:0]   product_q, product_d;
    logic             busy_q, done_q;

    // One iteration: add the multiplicand into the upper half when the
    // current multiplier LSB is set, then shift right keeping the carry.
    logic [W-1:0]     addend;
    logic [W-1:0]     sum;
    logic             cout;
    logic [2*W-1:0]   acc_iter;

    assign addend = acc_q[0] ? mcand_q : '0;

    add_slice #(.W(W)) u_add (
        .x    (acc_q[2*W-1:W]),
        .y    (addend),
        .cin  (1'b0),
        .sum  (sum),
        .cout (cout)
    );

    assign acc_iter = {cout, sum, acc_q[W-1:1]};

    always_comb begin
        state_d   = state_q;
        mcand_d   = mcand_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        product_d = product_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    mcand_d = a;
                    acc_d   = {{W{1'b0}}, b};
                    cnt_d   = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                acc_d = acc_iter;
                if (cnt_q == CNT_LAST) begin
                    product_d = acc_iter;
                    state_d   = ST_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // busy/done are decoded from the next state so they are registered
    // yet track the state register exactly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            mcand_q   <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            product_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            mcand_q   <= mcand_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            product_q <= product_d;
            busy_q    <= (state_d == ST_RUN);
            done_q    <= (state_d == ST_DONE);
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign product = product_q;

endmodule : mult_seq_ctrl
